// File: rtl/frodo_mul_seq_if.sv
// Handshake bundle between the frodoMul sequencer, its command source,
// the memory-side streamers and the frodoMul control inputs.
interface frodo_mul_seq_if #(
  parameter int CNT_W = 12
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mul1;
  logic             cmd_pos;
  logic [CNT_W-1:0] cmd_len;

  logic             ld_valid;
  logic             ld_ready;

  logic             in_valid;
  logic             in_ready;

  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  logic             mul_isMatrixMul1;
  logic             mul_isPos;
  logic             mul_setStorage;
  logic             mul_doOp;

  logic             busy;
  logic             done;

  // Environment side: issues commands, feeds beats, consumes results.
  modport master (
    output cmd_valid, cmd_mul1, cmd_pos, cmd_len,
    output ld_valid, in_valid, out_ready,
    input  cmd_ready, ld_ready, in_ready, out_valid, out_last,
    input  mul_isMatrixMul1, mul_isPos, mul_setStorage, mul_doOp,
    input  busy, done
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_mul1, cmd_pos, cmd_len,
    input  ld_valid, in_valid, out_ready,
    output cmd_ready, ld_ready, in_ready, out_valid, out_last,
    output mul_isMatrixMul1, mul_isPos, mul_setStorage, mul_doOp,
    output busy, done
  );
endinterface

// File: rtl/frodo_mul_seq.sv
// Command sequencer for one frodoMul multiply-accumulate instance: one load
// beat, K operand beats, then the result beat(s) for mul1 or mul2.
module frodo_mul_seq #(
  parameter int A     = 4,
  parameter int S     = 8,
  parameter int CNT_W = 12
) (
  input logic            clk,
  input logic            rst,
  frodo_mul_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN1,
    OUT1,
    RUN2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic             mode;
  logic             pos;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] cnt;
  logic             done_q;

  logic [CNT_W-1:0] len_m1;
  logic             len_zero;
  logic             at_last;
  logic             run2_xfer;

  // len_m1 is only consulted in RUN1/RUN2, where len is known to be non-zero.
  assign len_m1    = len - CNT_ONE;
  assign len_zero  = (len == '0);
  assign at_last   = (cnt == len_m1);
  assign run2_xfer = bus.in_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mode   <= 1'b0;
      pos    <= 1'b0;
      len    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            mode  <= bus.cmd_mul1;
            pos   <= bus.cmd_pos;
            len   <= bus.cmd_len;
            cnt   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (bus.ld_valid) begin
            if (mode) begin
              state <= len_zero ? OUT1 : RUN1;
            end else if (!len_zero) begin
              state <= RUN2;
            end else begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        RUN1: begin
          if (bus.in_valid) begin
            cnt <= cnt + CNT_ONE;
            if (at_last) begin
              state <= OUT1;
            end
          end
        end
        OUT1: begin
          if (bus.out_ready) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        RUN2: begin
          if (run2_xfer) begin
            cnt <= cnt + CNT_ONE;
            if (at_last) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stream readiness and frodoMul strobes follow the current state; in RUN2 the
  // result is combinational from the operand, so the two streams are coupled.
  always_comb begin
    bus.cmd_ready        = 1'b0;
    bus.ld_ready         = 1'b0;
    bus.in_ready         = 1'b0;
    bus.out_valid        = 1'b0;
    bus.out_last         = 1'b0;
    bus.mul_setStorage   = 1'b0;
    bus.mul_doOp         = 1'b0;
    bus.mul_isMatrixMul1 = mode;
    bus.mul_isPos        = pos;
    bus.busy             = (state != IDLE);
    bus.done             = done_q;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
      end
      LOAD: begin
        bus.ld_ready       = 1'b1;
        bus.mul_setStorage = bus.ld_valid;
      end
      RUN1: begin
        bus.in_ready = 1'b1;
        bus.mul_doOp = bus.in_valid;
      end
      OUT1: begin
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
      end
      RUN2: begin
        bus.out_valid = bus.in_valid;
        bus.in_ready  = bus.out_ready;
        bus.mul_doOp  = run2_xfer;
        bus.out_last  = at_last;
      end
      default: begin
        bus.cmd_ready = 1'b0;
      end
    endcase
  end

  // Structural sanity of the frodoMul strobes.
  assert property (@(posedge clk) disable iff (!rst)
    !(bus.mul_setStorage && bus.mul_doOp));

  assert property (@(posedge clk) disable iff (!rst)
    (bus.mul_setStorage || bus.mul_doOp) |-> (state == LOAD || state == RUN1 || state == RUN2));

  assert property (@(posedge clk) (A > 0) && (S > 0));

endmodule

// File: tb/tb_frodo_mul_seq.sv
// Directed bench for frodo_mul_seq with a scalar stand-in for one frodoMul row
// so that control sequencing is checked through the numeric result.
module tb_frodo_mul_seq;

  localparam int CNT_W = 12;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  frodo_mul_seq_if #(.CNT_W(CNT_W)) bus ();

  frodo_mul_seq #(
    .A    (4),
    .S    (8),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [15:0] ld_data;
  logic [15:0] a_val;
  logic [15:0] s_val;
  logic [15:0] acc_mat;
  logic [15:0] acc_vec;
  logic [15:0] s_col;
  logic [15:0] out_data;

  int checks   = 0;
  int failures = 0;

  // One row of frodoMul: mul1 accumulates into accVec, mul2 is combinational from sCol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_vec <= '0;
      s_col   <= '0;
    end else if (bus.mul_setStorage) begin
      if (bus.mul_isMatrixMul1) acc_vec <= ld_data;
      else                      s_col   <= ld_data;
    end else if (bus.mul_doOp && bus.mul_isMatrixMul1) begin
      acc_vec <= bus.mul_isPos ? acc_vec + a_val * s_val : acc_vec - a_val * s_val;
    end
  end

  always_comb begin
    out_data = '0;
    if (bus.mul_isMatrixMul1) out_data = acc_vec;
    else if (bus.mul_isPos)   out_data = acc_mat + s_col * a_val;
    else                      out_data = acc_mat - s_col * a_val;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic cv, input logic m1, input logic p,
                               input logic [CNT_W-1:0] len,
                               input logic lv, input logic iv, input logic orr);
    bus.cmd_valid = cv;
    bus.cmd_mul1  = m1;
    bus.cmd_pos   = p;
    bus.cmd_len   = len;
    bus.ld_valid  = lv;
    bus.in_valid  = iv;
    bus.out_ready = orr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_cmd(input logic m1, input logic p, input logic [CNT_W-1:0] len);
    next_cycle();
    applyStimulus(1'b1, m1, p, len, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("cmd_ready_idle", 32'(bus.cmd_ready), 1);
  endtask

  task automatic load_beat(input logic [15:0] data);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    ld_data = data;
    #1;
    checkOutput("ld_ready", 32'(bus.ld_ready), 1);
    checkOutput("set_storage", 32'(bus.mul_setStorage), 1);
  endtask

  task automatic run1_beats(input int n, input logic [15:0] a, input logic [15:0] s);
    for (int b = 0; b < n; b++) begin
      next_cycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
      a_val = a;
      s_val = s;
      #1;
      checkOutput("run1_in_ready", 32'(bus.in_ready), 1);
      checkOutput("run1_do_op", 32'(bus.mul_doOp), 1);
      checkOutput("run1_no_out", 32'(bus.out_valid), 0);
    end
  endtask

  // One stalled OUT1 cycle (with stray ld/in valids), then the handshake, then done.
  task automatic finish_out1(input logic [15:0] exp);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("out1_valid", 32'(bus.out_valid), 1);
    checkOutput("out1_last", 32'(bus.out_last), 1);
    checkOutput("out1_data", 32'(out_data), 32'(exp));
    checkOutput("out1_do_op", 32'(bus.mul_doOp), 0);
    checkOutput("out1_set_storage", 32'(bus.mul_setStorage), 0);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("out1_hold_valid", 32'(bus.out_valid), 1);
    checkOutput("out1_hold_data", 32'(out_data), 32'(exp));
    next_cycle();
    idle_inputs();
    #1;
    checkOutput("out1_done", 32'(bus.done), 1);
    checkOutput("out1_idle_busy", 32'(bus.busy), 0);
    checkOutput("out1_idle_cmd_ready", 32'(bus.cmd_ready), 1);
  endtask

  initial begin
    int   beats;
    logic orr;

    rst     = 1'b0;
    ld_data = '0;
    a_val   = '0;
    s_val   = '0;
    acc_mat = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 1'b1, 1'b1);

    // Reset state, with every stream offered
    #12;
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_ld_ready", 32'(bus.ld_ready), 0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_set_storage", 32'(bus.mul_setStorage), 0);
    checkOutput("rst_done", 32'(bus.done), 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;

    // T1: mul1 add, K=3, acc 1 + 3*(2*1) = 7
    start_cmd(1'b1, 1'b1, 12'd3);
    load_beat(16'd1);
    checkOutput("t1_is_mul1", 32'(bus.mul_isMatrixMul1), 1);
    checkOutput("t1_is_pos", 32'(bus.mul_isPos), 1);
    checkOutput("t1_busy", 32'(bus.busy), 1);
    run1_beats(3, 16'd2, 16'd1);
    finish_out1(16'd7);
    next_cycle();
    #1;
    checkOutput("t1_done_one_cycle", 32'(bus.done), 0);

    // T2: mul2 subtract, K=4, 100 - 2*3 = 94, consumer toggling
    start_cmd(1'b0, 1'b0, 12'd4);
    load_beat(16'd2);
    checkOutput("t2_is_pos", 32'(bus.mul_isPos), 0);
    checkOutput("t2_is_mul1", 32'(bus.mul_isMatrixMul1), 0);
    acc_mat = 16'd100;
    a_val   = 16'd3;
    beats   = 0;
    for (int i = 0; i < 20 && beats < 4; i++) begin
      next_cycle();
      orr = (i % 2 == 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b1, orr);
      #1;
      checkOutput("t2_in_ready", 32'(bus.in_ready), 32'(orr));
      checkOutput("t2_out_valid", 32'(bus.out_valid), 1);
      checkOutput("t2_do_op", 32'(bus.mul_doOp), 32'(orr));
      checkOutput("t2_out_last", 32'(bus.out_last), 32'(beats == 3));
      checkOutput("t2_out_data", 32'(out_data), 94);
      if (orr) beats++;
    end
    checkOutput("t2_beats", 32'(beats), 4);
    next_cycle();
    idle_inputs();
    #1;
    checkOutput("t2_done", 32'(bus.done), 1);
    checkOutput("t2_out_valid_after", 32'(bus.out_valid), 0);

    // T3: K=0 for both modes
    start_cmd(1'b1, 1'b1, 12'd0);
    load_beat(16'h1234);
    finish_out1(16'h1234);
    start_cmd(1'b0, 1'b1, 12'd0);
    load_beat(16'd5);
    next_cycle();
    idle_inputs();
    #1;
    checkOutput("t3_mul2_done", 32'(bus.done), 1);
    checkOutput("t3_mul2_busy", 32'(bus.busy), 0);
    checkOutput("t3_mul2_no_out", 32'(bus.out_valid), 0);

    // T4: producer stall of 5 cycles mid-RUN1
    start_cmd(1'b1, 1'b1, 12'd3);
    load_beat(16'd1);
    run1_beats(1, 16'd2, 16'd1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      idle_inputs();
      #1;
      checkOutput("t4_stall_do_op", 32'(bus.mul_doOp), 0);
      checkOutput("t4_stall_in_ready", 32'(bus.in_ready), 1);
      checkOutput("t4_stall_no_out", 32'(bus.out_valid), 0);
    end
    run1_beats(2, 16'd2, 16'd1);
    finish_out1(16'd7);

    // T5: reset during RUN1 beat 2 of 3, then a fresh command
    start_cmd(1'b1, 1'b1, 12'd3);
    load_beat(16'd1);
    run1_beats(1, 16'd2, 16'd1);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("t5_cmd_ready", 32'(bus.cmd_ready), 1);
    checkOutput("t5_busy", 32'(bus.busy), 0);
    checkOutput("t5_in_ready", 32'(bus.in_ready), 0);
    checkOutput("t5_do_op", 32'(bus.mul_doOp), 0);
    checkOutput("t5_is_mul1", 32'(bus.mul_isMatrixMul1), 0);
    checkOutput("t5_is_pos", 32'(bus.mul_isPos), 0);
    checkOutput("t5_done", 32'(bus.done), 0);
    #1;
    rst = 1'b1;
    start_cmd(1'b1, 1'b1, 12'd2);
    load_beat(16'd5);
    run1_beats(2, 16'd1, 16'd1);
    finish_out1(16'd7);

    // T6: back-to-back with cmd_valid held, isPos changes only at acceptance
    next_cycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 12'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("t6_first_accept", 32'(bus.cmd_ready), 1);
    next_cycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 12'd1, 1'b1, 1'b0, 1'b0);
    ld_data = 16'd9;
    #1;
    checkOutput("t6_load_cmd_ready", 32'(bus.cmd_ready), 0);
    checkOutput("t6_load_is_pos", 32'(bus.mul_isPos), 1);
    checkOutput("t6_load_set_storage", 32'(bus.mul_setStorage), 1);
    next_cycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 12'd1, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("t6_done", 32'(bus.done), 1);
    checkOutput("t6_done_cmd_ready", 32'(bus.cmd_ready), 1);
    checkOutput("t6_done_is_pos", 32'(bus.mul_isPos), 1);
    next_cycle();
    idle_inputs();
    #1;
    checkOutput("t6_second_done_clear", 32'(bus.done), 0);
    checkOutput("t6_second_is_pos", 32'(bus.mul_isPos), 0);
    checkOutput("t6_second_is_mul1", 32'(bus.mul_isMatrixMul1), 1);
    checkOutput("t6_second_ld_ready", 32'(bus.ld_ready), 1);
    load_beat(16'd10);
    run1_beats(1, 16'd3, 16'd2);
    finish_out1(16'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
